mips_lsu: RTL and testbench

- Load/store unit in the MIPS32 memory stage, directly upstream of the data-memory interface (DataMem_*).
- Converts byte/half/word load and store requests from the pipeline into word-addressed memory transactions with byte-lane enables.
- Steers and extends load data, stalls the pipeline until each access completes, and flags alignment faults and timeouts.

---
 rtl/mips_lsu_pkg.sv | 43 ++++
 rtl/mips_lsu_if.sv | 36 +++
 rtl/mips_lsu_align.sv | 47 ++++
 rtl/mips_lsu.sv | 147 ++++++++++++++
 tb/tb_mips_lsu.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/mips_lsu_pkg.sv
// Shared types, widths and lane helpers for the MIPS32 load/store unit.
package mips_lsu_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned DATA_W  = 32;
  localparam int unsigned WADDR_W = 30;
  localparam int unsigned BE_W    = 4;
  localparam int unsigned TMO_W   = 8;

  typedef enum logic [2:0] {
    IDLE,
    RD_WAIT,
    WR,
    WR_WAIT,
    DONE
  } lsu_state_t;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD,
    SZ_RSVD
  } lsu_size_t;

  // Big-endian byte enables; bit 3 is the most significant lane.
  function automatic logic [BE_W-1:0] byte_enable(lsu_size_t size, logic [1:0] offset);
    case (size)
      SZ_BYTE: return 4'b1000 >> offset;
      SZ_HALF: return offset[1] ? 4'b0011 : 4'b1100;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic misaligned(lsu_size_t size, logic [1:0] offset);
    case (size)
      SZ_HALF: return offset[0];
      SZ_WORD: return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Pipeline request/response and data-memory bus of the load/store unit.
interface mips_lsu_if;
  import mips_lsu_pkg::*;

  logic               M_MemRead;
  logic               M_MemWrite;
  logic [1:0]         M_Size;
  logic               M_Unsigned;
  logic [ADDR_W-1:0]  M_Address;
  logic [DATA_W-1:0]  M_WriteData;
  logic [DATA_W-1:0]  M_ReadData;
  logic               M_Stall;
  logic               M_AddrError;
  logic               M_BusError;
  logic [DATA_W-1:0]  DataMem_In;
  logic               DataMem_Ready;
  logic               DataMem_Read;
  logic [BE_W-1:0]    DataMem_Write;
  logic [WADDR_W-1:0] DataMem_Address;
  logic [DATA_W-1:0]  DataMem_Out;

  // The LSU masters the memory bus and answers the pipeline.
  modport master (
    input  M_MemRead, M_MemWrite, M_Size, M_Unsigned, M_Address, M_WriteData,
    input  DataMem_In, DataMem_Ready,
    output M_ReadData, M_Stall, M_AddrError, M_BusError,
    output DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out
  );

  modport slave (
    output M_MemRead, M_MemWrite, M_Size, M_Unsigned, M_Address, M_WriteData,
    output DataMem_In, DataMem_Ready,
    input  M_ReadData, M_Stall, M_AddrError, M_BusError,
    input  DataMem_Read, DataMem_Write, DataMem_Address, DataMem_Out
  );
endinterface

// File: rtl/mips_lsu_align.sv
// Store-lane replication and big-endian load-lane extraction with sign/zero extension.
module mips_lsu_align
  import mips_lsu_pkg::*;
(
  input  lsu_size_t         size,
  input  logic [1:0]        offset,
  input  logic              zero_ext,
  input  logic [DATA_W-1:0] store_data,
  input  logic [DATA_W-1:0] mem_data,
  output logic [DATA_W-1:0] store_lanes_c,
  output logic [DATA_W-1:0] load_data_c
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    store_lanes_c = store_data;
    case (size)
      SZ_BYTE: store_lanes_c = {4{store_data[7:0]}};
      SZ_HALF: store_lanes_c = {2{store_data[15:0]}};
      default: store_lanes_c = store_data;
    endcase
  end

  // Offset 0 is the most significant byte of the word.
  always_comb begin
    lane_b = mem_data[31:24];
    case (offset)
      2'd0:    lane_b = mem_data[31:24];
      2'd1:    lane_b = mem_data[23:16];
      2'd2:    lane_b = mem_data[15:8];
      default: lane_b = mem_data[7:0];
    endcase
    lane_h = offset[1] ? mem_data[15:0] : mem_data[31:16];
  end

  always_comb begin
    load_data_c = mem_data;
    case (size)
      SZ_BYTE: load_data_c = zero_ext ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      SZ_HALF: load_data_c = zero_ext ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_data_c = mem_data;
    endcase
  end

endmodule

// File: rtl/mips_lsu.sv
// MIPS32 memory-stage load/store unit: issues word-addressed accesses, stalls
// the pipeline until completion and flags alignment faults and bus timeouts.
module mips_lsu
  import mips_lsu_pkg::*;
#(
  parameter bit          WRITE_ACK      = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input logic        clock,
  input logic        reset,
  mips_lsu_if.master bus
);

  lsu_state_t         state, state_next;
  lsu_size_t          size;
  logic [1:0]         offset;
  logic               req_error, issue, expire;
  logic [TMO_W-1:0]   tmo_cnt, cnt_d;
  logic               rd_q, rd_d;
  logic [BE_W-1:0]    we_q, we_d;
  logic [WADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0]  out_q, out_d;
  logic [DATA_W-1:0]  rdata_q, rdata_d;
  logic               buserr_q, buserr_d;
  logic [DATA_W-1:0]  store_lanes_c, load_data_c;
  logic               stall_c, addr_error_c;

  assign size   = lsu_size_t'(bus.M_Size);
  assign offset = bus.M_Address[1:0];

  assign req_error = (bus.M_MemRead | bus.M_MemWrite) &
                     ((bus.M_MemRead & bus.M_MemWrite) | (size == SZ_RSVD) |
                      misaligned(size, offset));
  assign issue     = (bus.M_MemRead ^ bus.M_MemWrite) & ~req_error;
  // Counter starts at 0 on the first wait cycle, so expiry is on the last allowed one.
  assign expire    = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  mips_lsu_align u_align (
    .size          (size),
    .offset        (offset),
    .zero_ext      (bus.M_Unsigned),
    .store_data    (bus.M_WriteData),
    .mem_data      (bus.DataMem_In),
    .store_lanes_c (store_lanes_c),
    .load_data_c   (load_data_c)
  );

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (issue) state_next = bus.M_MemRead ? RD_WAIT : WR;
      RD_WAIT: if (bus.DataMem_Ready || expire) state_next = DONE;
      WR:      state_next = WRITE_ACK ? WR_WAIT : DONE;
      WR_WAIT: if (bus.DataMem_Ready || expire) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Ready takes priority over timeout expiry in the wait states.
  always_comb begin
    stall_c      = 1'b0;
    addr_error_c = 1'b0;
    rd_d         = 1'b0;
    we_d         = '0;
    addr_d       = addr_q;
    out_d        = out_q;
    rdata_d      = rdata_q;
    buserr_d     = 1'b0;
    cnt_d        = tmo_cnt;
    case (state)
      IDLE: begin
        addr_error_c = req_error & ~reset;
        if (issue) begin
          stall_c = 1'b1;
          addr_d  = bus.M_Address[31:2];
          cnt_d   = '0;
          if (bus.M_MemRead) begin
            rd_d = 1'b1;
          end else begin
            we_d  = byte_enable(size, offset);
            out_d = store_lanes_c;
          end
        end
      end
      RD_WAIT: begin
        stall_c = 1'b1;
        if (bus.DataMem_Ready) begin
          rdata_d = load_data_c;
        end else if (expire) begin
          rdata_d  = '0;
          buserr_d = 1'b1;
        end else begin
          rd_d  = 1'b1;
          cnt_d = tmo_cnt + TMO_W'(1);
        end
      end
      WR: begin
        stall_c = 1'b1;
        cnt_d   = '0;
      end
      WR_WAIT: begin
        stall_c = 1'b1;
        if (!bus.DataMem_Ready) begin
          if (expire) buserr_d = 1'b1;
          else        cnt_d    = tmo_cnt + TMO_W'(1);
        end
      end
      default: stall_c = 1'b0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_q     <= 1'b0;
      we_q     <= '0;
      addr_q   <= '0;
      out_q    <= '0;
      rdata_q  <= '0;
      buserr_q <= 1'b0;
      tmo_cnt  <= '0;
    end else begin
      rd_q     <= rd_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      out_q    <= out_d;
      rdata_q  <= rdata_d;
      buserr_q <= buserr_d;
      tmo_cnt  <= cnt_d;
    end
  end

  assign bus.DataMem_Read    = rd_q;
  assign bus.DataMem_Write   = we_q;
  assign bus.DataMem_Address = addr_q;
  assign bus.DataMem_Out     = out_q;
  assign bus.M_ReadData      = rdata_q;
  assign bus.M_BusError      = buserr_q;
  assign bus.M_Stall         = stall_c;
  assign bus.M_AddrError     = addr_error_c;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed-vector bench for mips_lsu against a small registered-ready memory model.
module tb_mips_lsu;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic dead  = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  logic [31:0] mem [0:15];
  logic [3:0]  last_we;
  logic [31:0] last_out;
  logic        rd_with_we;
  int          strobe_cycles = 0;

  mips_lsu_if bus ();

  mips_lsu #(.WRITE_ACK(1'b0), .TIMEOUT_CYCLES(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Memory: read data and Ready registered one cycle after the strobe.
  always @(posedge clock) begin
    if (|bus.DataMem_Write) begin
      for (int b = 0; b < 4; b++)
        if (bus.DataMem_Write[b]) mem[bus.DataMem_Address[3:0]][8*b +: 8] <= bus.DataMem_Out[8*b +: 8];
    end
    bus.DataMem_In    <= mem[bus.DataMem_Address[3:0]];
    bus.DataMem_Ready <= ~dead & (bus.DataMem_Read | (|bus.DataMem_Write));
  end

  always @(negedge clock) begin
    if (bus.DataMem_Read || (|bus.DataMem_Write)) strobe_cycles++;
    if (|bus.DataMem_Write) begin
      last_we    = bus.DataMem_Write;
      last_out   = bus.DataMem_Out;
      rd_with_we = bus.DataMem_Read;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.M_MemRead   = 1'b0;
    bus.M_MemWrite  = 1'b0;
    bus.M_Size      = 2'd0;
    bus.M_Unsigned  = 1'b0;
    bus.M_Address   = '0;
    bus.M_WriteData = '0;
  endtask

  // Holds a request until stall drops; cycles = index of the first unstalled cycle.
  task automatic run_req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] wd,
                         output int cycles, output logic [31:0] rdata,
                         output logic aerr, output logic berr);
    @(posedge clock); #1;
    bus.M_MemRead   = rd;
    bus.M_MemWrite  = wr;
    bus.M_Size      = sz;
    bus.M_Unsigned  = uns;
    bus.M_Address   = a;
    bus.M_WriteData = wd;
    cycles = 0;
    @(negedge clock);
    while (bus.M_Stall && cycles < 50) begin
      @(negedge clock);
      cycles++;
    end
    rdata = bus.M_ReadData;
    aerr  = bus.M_AddrError;
    berr  = bus.M_BusError;
    @(posedge clock); #1;
    idle_inputs();
  endtask

  int          cyc;
  logic [31:0] rdata;
  logic        aerr, berr;
  int          strobes_before;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = '0;
    mem[1] = 32'h8081_7F02;
    idle_inputs();
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    check("rst_rd",    32'(bus.DataMem_Read),    32'h0);
    check("rst_we",    32'(bus.DataMem_Write),   32'h0);
    check("rst_addr",  32'(bus.DataMem_Address), 32'h0);
    check("rst_out",   bus.DataMem_Out,          32'h0);
    check("rst_rdata", bus.M_ReadData,           32'h0);
    check("rst_stall", 32'(bus.M_Stall),         32'h0);
    check("rst_berr",  32'(bus.M_BusError),      32'h0);

    run_req(1, 0, 2'd0, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("lb_cycles", 32'(cyc), 32'd3);
    check("lb_data",   rdata,    32'hFFFF_FF80);
    check("lb_waddr",  32'(bus.DataMem_Address), 32'h801);
    run_req(1, 0, 2'd0, 1, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("lbu_data",  rdata,    32'h0000_0080);
    run_req(1, 0, 2'd1, 0, 32'h2006, 0, cyc, rdata, aerr, berr);
    check("lh_data",   rdata,    32'h0000_7F02);
    run_req(1, 0, 2'd2, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("lw_data",   rdata,    32'h8081_7F02);

    run_req(0, 1, 2'd0, 0, 32'h2005, 32'h0000_00AB, cyc, rdata, aerr, berr);
    check("sb_cycles", 32'(cyc),        32'd2);
    check("sb_we",     32'(last_we),    32'h4);
    check("sb_out",    last_out,        32'hABAB_ABAB);
    check("sb_no_rd",  32'(rd_with_we), 32'h0);
    check("sb_mem",    mem[1],          32'h80AB_7F02);
    run_req(0, 1, 2'd1, 0, 32'h2006, 32'h5555_1234, cyc, rdata, aerr, berr);
    check("sh_we",     32'(last_we),    32'h3);
    check("sh_out",    last_out,        32'h1234_1234);
    check("sh_mem",    mem[1],          32'h80AB_1234);
    run_req(1, 0, 2'd1, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("lh_neg",    rdata,           32'hFFFF_80AB);
    run_req(1, 0, 2'd0, 1, 32'h2007, 0, cyc, rdata, aerr, berr);
    check("lbu_off3",  rdata,           32'h0000_0034);

    strobes_before = strobe_cycles;
    run_req(1, 0, 2'd2, 0, 32'h2002, 0, cyc, rdata, aerr, berr);
    check("lw_mis_aerr",  32'(aerr), 32'h1);
    check("lw_mis_stall", 32'(cyc),  32'd0);
    run_req(1, 0, 2'd1, 0, 32'h2005, 0, cyc, rdata, aerr, berr);
    check("lh_mis_aerr",  32'(aerr), 32'h1);
    run_req(1, 0, 2'd3, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("rsvd_aerr",    32'(aerr), 32'h1);
    run_req(1, 1, 2'd2, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("rdwr_aerr",    32'(aerr), 32'h1);
    check("rdwr_stall",   32'(cyc),  32'd0);
    check("err_no_strobe", 32'(strobe_cycles), 32'(strobes_before));
    @(negedge clock);
    check("aerr_clear",   32'(bus.M_AddrError), 32'h0);

    dead = 1'b1;
    run_req(1, 0, 2'd2, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("tmo_cycles", 32'(cyc),  32'd5);
    check("tmo_berr",   32'(berr), 32'h1);
    check("tmo_rdata",  rdata,     32'h0);
    @(negedge clock);
    check("tmo_pulse",  32'(bus.M_BusError), 32'h0);
    check("tmo_idle",   32'(bus.M_Stall),    32'h0);

    @(posedge clock); #1;
    bus.M_MemRead = 1'b1;
    bus.M_Size    = 2'd2;
    bus.M_Address = 32'h2004;
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b1;
    idle_inputs();
    @(posedge clock); #1;
    reset = 1'b0;
    dead  = 1'b0;
    @(negedge clock);
    check("rstmid_rd",    32'(bus.DataMem_Read), 32'h0);
    check("rstmid_stall", 32'(bus.M_Stall),      32'h0);
    run_req(1, 0, 2'd2, 0, 32'h2004, 0, cyc, rdata, aerr, berr);
    check("rstmid_lw_cycles", 32'(cyc), 32'd3);
    check("rstmid_lw_data",   rdata,    32'h80AB_1234);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
